// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arb_pkg
//  Description : Shared types and widths for the nametable VRAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_arb_pkg;

    localparam int VRAM_AW = 11;
    localparam int PPU_AW  = 14;

    // Cartridge nametable mirroring, encoded as the mirror_mode input bits.
    typedef enum logic [1:0] {
        MIR_HORIZ    = 2'b00,
        MIR_VERT     = 2'b01,
        MIR_SINGLE_A = 2'b10,
        MIR_SINGLE_B = 2'b11
    } mirror_e;

    // Which requester a granted read belongs to.
    typedef enum logic {
        OWN_REN = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/nt_mirror_map.sv
`default_nettype none
// ============================================================================
//  Module      : nt_mirror_map
//  Description : Combinational PPU nametable address to 11-bit VRAM address
//                translation for the four cartridge mirroring modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module nt_mirror_map
    import vram_arb_pkg::*;
(
    input  logic [PPU_AW-1:0]  ppu_addr,
    input  mirror_e            mode,
    output logic [VRAM_AW-1:0] vram_addr
);

    logic [1:0] w_table;
    logic       w_bank;
    logic       w_unused_hi;

    // Logical nametable 0..3; bits 13:12 only distinguish the $3000 mirror.
    assign w_table     = ppu_addr[11:10];
    assign w_unused_hi = ^ppu_addr[13:12];

    // Select the physical 1 KiB bank for the logical nametable.
    always_comb begin
        w_bank = 1'b0;
        case (mode)
            MIR_HORIZ:    w_bank = w_table[1];
            MIR_VERT:     w_bank = w_table[0];
            MIR_SINGLE_A: w_bank = 1'b0;
            MIR_SINGLE_B: w_bank = 1'b1;
            default:      w_bank = 1'b0;
        endcase
    end

    assign vram_addr = {w_bank, ppu_addr[9:0]};

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter
//  Description : Single-port nametable VRAM arbiter between PPU render fetches
//                and CPU PPUDATA accesses, with mirroring address translation
//                and one-cycle read return. Render has priority; defining
//                VRAM_ARB_STARVE_GUARD_EN adds a counter that forces the CPU
//                in after STARVE_LIMIT consecutive blocking render grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mirror_mode,
    input  logic               ren_req,
    input  logic [PPU_AW-1:0]  ren_addr,
    output logic               ren_gnt,
    output logic               ren_rvalid,
    output logic [7:0]         ren_rdata,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [PPU_AW-1:0]  cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [7:0]         cpu_rdata,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_we,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata
);

    logic               w_force_cpu;
    logic               w_cpu_win;
    logic               w_ren_win;
    logic               w_any_win;
    logic [PPU_AW-1:0]  w_win_addr;
    logic [VRAM_AW-1:0] w_map_addr;
    logic               w_rd_valid;
    logic               r_rd_valid;
    owner_e             r_rd_owner;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] c_limit = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;

    assign w_force_cpu = cpu_req && (r_starve_cnt == c_limit);

    // Count render grants that block a waiting CPU; clear once it gets in or stops asking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 8'd0;
        end else if (!cpu_req || w_cpu_win) begin
            r_starve_cnt <= 8'd0;
        end else if (w_ren_win) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`else
    logic [7:0] w_unused_limit;

    assign w_unused_limit = 8'(STARVE_LIMIT);
    assign w_force_cpu    = 1'b0;
`endif

    // No grants at all while reset is held.
    assign w_cpu_win  = !rst && cpu_req && (!ren_req || w_force_cpu);
    assign w_ren_win  = !rst && ren_req && !w_cpu_win;
    assign w_any_win  = w_cpu_win || w_ren_win;
    assign w_win_addr = w_cpu_win ? cpu_addr : ren_addr;

    assign ren_gnt = w_ren_win;
    assign cpu_gnt = w_cpu_win;

    nt_mirror_map u_map (
        .ppu_addr  (w_win_addr),
        .mode      (mirror_e'(mirror_mode)),
        .vram_addr (w_map_addr)
    );

    assign vram_addr  = w_any_win ? w_map_addr : '0;
    assign vram_we    = w_cpu_win && cpu_we;
    assign vram_wdata = w_cpu_win ? cpu_wdata : 8'h00;

    // Remember who owns the read in flight so the returning byte is routed back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= OWN_REN;
        end else begin
            r_rd_valid <= w_ren_win || (w_cpu_win && !cpu_we);
            r_rd_owner <= w_cpu_win ? OWN_CPU : OWN_REN;
        end
    end

    // Reset in the return cycle drops the result.
    assign w_rd_valid = r_rd_valid && !rst;
    assign ren_rvalid = w_rd_valid && (r_rd_owner == OWN_REN);
    assign cpu_rvalid = w_rd_valid && (r_rd_owner == OWN_CPU);
    assign ren_rdata  = ren_rvalid ? vram_rdata : 8'h00;
    assign cpu_rdata  = cpu_rvalid ? vram_rdata : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_arbiter
//  Description : Self-checking bench for vram_arbiter: directed scenarios with
//                literal expectations plus randomized traffic against a
//                behavioural model of arbitration, mirroring and read return.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int c_limit = 4;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit c_guard = 1'b1;
`else
    localparam bit c_guard = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  mirror_mode;
    logic        ren_req;
    logic [13:0] ren_addr;
    logic        ren_gnt;
    logic        ren_rvalid;
    logic [7:0]  ren_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [10:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;

    int n_vec = 0;
    int n_err = 0;

    vram_arbiter #(.STARVE_LIMIT(c_limit)) dut (
        .clk         (clk),
        .rst         (rst),
        .mirror_mode (mirror_mode),
        .ren_req     (ren_req),
        .ren_addr    (ren_addr),
        .ren_gnt     (ren_gnt),
        .ren_rvalid  (ren_rvalid),
        .ren_rdata   (ren_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .vram_addr   (vram_addr),
        .vram_we     (vram_we),
        .vram_wdata  (vram_wdata),
        .vram_rdata  (vram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural VRAM: registered read, synchronous write, no reset.
    logic [7:0] vmem [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++) vmem[i] = 8'h00;
        vram_rdata = 8'h00;
    end
    always @(posedge clk) begin
        if (vram_we) vmem[vram_addr] <= vram_wdata;
        vram_rdata <= vmem[vram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Nametable translation from the mirroring rules.
    function automatic logic [10:0] phys(input logic [1:0] mode, input logic [13:0] a);
        int t;
        int bank;
        t = int'(a[11:10]);
        case (mode)
            2'd0:    bank = t / 2;
            2'd1:    bank = t % 2;
            2'd2:    bank = 0;
            default: bank = 1;
        endcase
        return 11'(bank * 1024 + int'(a[9:0]));
    endfunction

    // ---------------- reference model and per-cycle compare ----------------
    logic [7:0] shadow [0:2047];
    logic       m_pv = 1'b0;
    logic       m_po = 1'b0;
    logic [7:0] m_pd = 8'h00;
    int         m_waits = 0;
    logic       m_cpu_wait = 1'b0;
    initial for (int i = 0; i < 2048; i++) shadow[i] = 8'h00;

    always @(negedge clk) begin : p_compare
        logic        e_force, e_cg, e_rg, e_rv_r, e_rv_c;
        logic [10:0] e_a;
        e_force = c_guard && cpu_req && (m_waits == c_limit);
        e_cg    = !rst && cpu_req && (!ren_req || e_force);
        e_rg    = !rst && ren_req && !e_cg;
        e_a     = e_cg ? phys(mirror_mode, cpu_addr) : (e_rg ? phys(mirror_mode, ren_addr) : 11'd0);
        e_rv_r  = !rst && m_pv && !m_po;
        e_rv_c  = !rst && m_pv && m_po;

        if (m_cpu_wait && !cpu_req && !rst) begin
            n_err++;
            $display("FAIL cpu_req_dropped: cpu_req 0 before cpu_gnt at %0t", $time);
        end

        check("ren_gnt",    32'(ren_gnt),    32'(e_rg));
        check("cpu_gnt",    32'(cpu_gnt),    32'(e_cg));
        check("vram_addr",  32'(vram_addr),  32'(e_a));
        check("vram_we",    32'(vram_we),    32'(e_cg && cpu_we));
        check("vram_wdata", 32'(vram_wdata), 32'(e_cg ? cpu_wdata : 8'h00));
        check("ren_rvalid", 32'(ren_rvalid), 32'(e_rv_r));
        check("ren_rdata",  32'(ren_rdata),  32'(e_rv_r ? m_pd : 8'h00));
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rv_c));
        check("cpu_rdata",  32'(cpu_rdata),  32'(e_rv_c ? m_pd : 8'h00));

        if (rst) begin
            m_pv       = 1'b0;
            m_waits    = 0;
            m_cpu_wait = 1'b0;
        end else begin
            m_pv = e_rg || (e_cg && !cpu_we);
            m_po = e_cg;
            m_pd = shadow[e_a];
            if (e_cg && cpu_we) shadow[e_a] = cpu_wdata;
            if (!cpu_req || e_cg) m_waits = 0;
            else if (e_rg)        m_waits = m_waits + 1;
            m_cpu_wait = cpu_req && !e_cg;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic rr, input logic [13:0] ra, input logic cr,
                          input logic cw, input logic [13:0] ca, input logic [7:0] cd);
        ren_req   = rr;
        ren_addr  = ra;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin : p_stim
        logic        cp;
        logic        cw_r;
        logic [13:0] ca_r;
        logic [7:0]  cd_r;
        rst = 1'b1;
        mirror_mode = 2'b00;
        set_in(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rst_ren_gnt", 32'(ren_gnt), 32'd0);
            check("rst_vram_addr", 32'(vram_addr), 32'd0);
            next();
        end
        rst = 1'b0;

        // Vertical: write $2400, read back through the $2C00 mirror.
        mirror_mode = 2'b01;
        set_in(1'b0, 14'h0, 1'b1, 1'b1, 14'h2400, 8'hA5);
        mid();
        check("v_wr_gnt", 32'(cpu_gnt), 32'd1);
        check("v_wr_addr", 32'(vram_addr), 32'h400);
        check("v_wr_we", 32'(vram_we), 32'd1);
        next();
        set_in(1'b0, 14'h0, 1'b1, 1'b0, 14'h2C00, 8'h00);
        mid();
        check("v_rd_addr", 32'(vram_addr), 32'h400);
        check("v_rd_we", 32'(vram_we), 32'd0);
        next();
        set_in(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h00);
        mid();
        check("v_rd_rvalid", 32'(cpu_rvalid), 32'd1);
        check("v_rd_rdata", 32'(cpu_rdata), 32'hA5);
        next();

        // Horizontal: preload 11/22/33 then back-to-back render reads.
        mirror_mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 14'h0, 1'b1, 1'b1, 14'(14'h2000 + i), 8'(8'h11 * (i + 1)));
            next();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(i < 3, 14'(14'h2000 + i), 1'b0, 1'b0, 14'h0, 8'h00);
            mid();
            if (i > 0) begin
                check("b2b_rvalid", 32'(ren_rvalid), 32'd1);
                check("b2b_rdata", 32'(ren_rdata), 32'(8'h11 * i));
                check("b2b_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            end
            next();
        end

        // Mirroring spot checks.
        set_in(1'b1, 14'h2800, 1'b0, 1'b0, 14'h0, 8'h00);
        mid(); check("h_2800", 32'(vram_addr), 32'h400); next();
        set_in(1'b1, 14'h2C05, 1'b0, 1'b0, 14'h0, 8'h00);
        mid(); check("h_2C05", 32'(vram_addr), 32'h405); next();
        mirror_mode = 2'b11;
        set_in(1'b1, 14'h2005, 1'b0, 1'b0, 14'h0, 8'h00);
        mid(); check("sb_2005", 32'(vram_addr), 32'h405); next();
        mirror_mode = 2'b10;
        set_in(1'b1, 14'h3805, 1'b0, 1'b0, 14'h0, 8'h00);
        mid(); check("sa_3805", 32'(vram_addr), 32'h005); next();

        // Contention: render wins while present, CPU gets in when it drops.
        mirror_mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 14'h2000, 1'b1, 1'b0, 14'h2001, 8'h00);
            mid();
            check("cont_ren_gnt", 32'(ren_gnt), 32'd1);
            check("cont_cpu_gnt", 32'(cpu_gnt), 32'd0);
            next();
        end
        set_in(1'b0, 14'h0, 1'b1, 1'b0, 14'h2001, 8'h00);
        mid(); check("cont_cpu_in", 32'(cpu_gnt), 32'd1); next();
        set_in(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h00);
        mid(); check("cont_cpu_rdata", 32'(cpu_rdata), 32'h22); next();

        // Starvation pattern with both requesters continuously asking.
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 14'(14'h2000 + i), 1'b1, 1'b0, 14'h2002, 8'h00);
            mid();
`ifdef VRAM_ARB_STARVE_GUARD_EN
            check("starve_cpu_gnt", 32'(cpu_gnt), 32'(i % 5 == 4));
            check("starve_ren_gnt", 32'(ren_gnt), 32'(i % 5 != 4));
`else
            check("strict_cpu_gnt", 32'(cpu_gnt), 32'd0);
            check("strict_ren_gnt", 32'(ren_gnt), 32'd1);
`endif
            next();
        end
        set_in(1'b0, 14'h0, 1'b1, 1'b0, 14'h2002, 8'h00);
        next();

        // Reset in the return cycle of a render read.
        set_in(1'b1, 14'h2000, 1'b0, 1'b0, 14'h0, 8'h00);
        mid(); check("pre_rst_gnt", 32'(ren_gnt), 32'd1); next();
        rst = 1'b1;
        mid();
        check("rst_rvalid_drop", 32'(ren_rvalid), 32'd0);
        check("rst_no_gnt", 32'(ren_gnt), 32'd0);
        check("rst_addr", 32'(vram_addr), 32'd0);
        next();
        rst = 1'b0;
        mid();
        check("post_rst_gnt", 32'(ren_gnt), 32'd1);
        check("post_rst_rvalid", 32'(ren_rvalid), 32'd0);
        next();
        set_in(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h00);
        mid();
        check("post_rst_data", 32'(ren_rdata), 32'h11);
        next();

        // Randomized traffic; CPU requests held until granted.
        cp = 1'b0; cw_r = 1'b0; ca_r = 14'h0; cd_r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (!cp && $urandom_range(0, 99) < 35) begin
                cp   = 1'b1;
                cw_r = 1'($urandom_range(0, 1));
                ca_r = 14'($urandom);
                cd_r = 8'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) mirror_mode = 2'($urandom);
            set_in($urandom_range(0, 99) < 60, 14'($urandom), cp, cw_r, ca_r, cd_r);
            mid();
            if (cpu_gnt) cp = 1'b0;
            next();
        end
        rst = 1'b0;
        set_in(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h00);
        repeat (3) next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
